// File: rtl/uart_tx_rr_arbiter.sv
// uart_tx_rr_arbiter: round-robin arbiter sharing one UART TX channel among NUM_REQ requesters
//   clk, rst     : clock, synchronous active-high reset
//   req_valid    : per-requester request, held until its req_ready pulse
//   req_data     : packed request bytes, requester i at [i*DATA_W +: DATA_W]
//   req_ready    : one-hot acceptance pulse (START cycle)
//   req_done     : one-hot pulse the cycle after tx_done for the granted requester
//   tx_start     : one-cycle start pulse to the UART TX
//   data_in      : latched byte to the UART TX, stable from START until next arbitration
//   tx_done      : UART TX frame-complete pulse
//   busy         : high in START and WAIT
//   grant_id     : index of the current or last granted requester
//   timeout_err  : one-cycle pulse when tx_done never arrives within TIMEOUT_CYC cycles
module uart_tx_rr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 131072,
    parameter int ID_W        = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        req_done,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         data_in,
    input  logic                      tx_done,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      timeout_err
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t                state, state_n;
    logic [ID_W-1:0]       last_grant, last_grant_n, win, idx, grant_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [DATA_W-1:0]     data_n;
    logic [NUM_REQ-1:0]    ready_n, done_n;
    logic                  tx_start_n, busy_n, to_n;

    // Scan from the farthest candidate down to last_grant+1 so the nearest
    // requester after the pointer is the final (winning) assignment.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (req_valid[idx]) win = idx;
        end
    end

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        cnt_n        = cnt;
        data_n       = data_in;
        grant_n      = grant_id;
        tx_start_n   = 1'b0;
        ready_n      = '0;
        done_n       = '0;
        to_n         = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_n    = START;
                    data_n     = req_data[win*DATA_W +: DATA_W];
                    grant_n    = win;
                    tx_start_n = 1'b1;
                    ready_n    = NUM_REQ'(1) << win;
                end
            end
            START: begin
                state_n = WAIT;
                cnt_n   = '0;
            end
            WAIT: begin
                cnt_n = cnt + 1'b1;
                // tx_done takes precedence over a timeout in the same cycle
                if (tx_done) begin
                    state_n      = IDLE;
                    done_n       = NUM_REQ'(1) << grant_id;
                    last_grant_n = grant_id;
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_n      = IDLE;
                    to_n         = 1'b1;
                    last_grant_n = grant_id;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= ID_W'(NUM_REQ - 1);
            cnt         <= '0;
            data_in     <= '0;
            grant_id    <= '0;
            tx_start    <= 1'b0;
            req_ready   <= '0;
            req_done    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            last_grant  <= last_grant_n;
            cnt         <= cnt_n;
            data_in     <= data_n;
            grant_id    <= grant_n;
            tx_start    <= tx_start_n;
            req_ready   <= ready_n;
            req_done    <= done_n;
            busy        <= busy_n;
            timeout_err <= to_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_rr_arbiter.sv
// tb_uart_tx_rr_arbiter: directed self-checking bench for uart_tx_rr_arbiter (TIMEOUT_CYC=100)
module tb_uart_tx_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready, req_done;
    logic        tx_start, tx_done, busy, timeout_err;
    logic [7:0]  data_in;
    logic [1:0]  grant_id;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    uart_tx_rr_arbiter #(
        .NUM_REQ(4), .DATA_W(8), .TIMEOUT_CYC(100), .ID_W(2)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .req_done(req_done), .tx_start(tx_start),
        .data_in(data_in), .tx_done(tx_done), .busy(busy),
        .grant_id(grant_id), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (!tx_start && n < 40) begin
            tick;
            n++;
        end
        chk(tag, 32'(tx_start), 1);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int last_s, n;
        logic [3:0] seen;
        logic [1:0] order [5];
        order = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        tx_done = 1'b0;
        tick;
        tick;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_txs", 32'(tx_start), 0);
        chk("rst_rdy_done", {req_ready, req_done}, 0);
        chk("rst_data_gid", {data_in, 6'd0, grant_id}, 0);
        chk("rst_to", 32'(timeout_err), 0);
        rst = 1'b0;

        // single request from requester 2
        req_data = 32'h00A5_0000;
        req_valid = 4'b0100;
        tick;
        chk("t1_txs", 32'(tx_start), 1);
        chk("t1_rdy", 32'(req_ready), 32'b0100);
        chk("t1_data", 32'(data_in), 32'hA5);
        chk("t1_gid", 32'(grant_id), 2);
        chk("t1_busy", 32'(busy), 1);
        req_valid = '0;
        tick;
        chk("t1_txs_once", 32'(tx_start), 0);
        chk("t1_rdy_once", 32'(req_ready), 0);
        repeat (19) tick;
        chk("t1_hold", {data_in, 6'd0, grant_id, 7'd0, busy}, {8'hA5, 6'd0, 2'd2, 7'd0, 1'b1});
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
        chk("t1_done", 32'(req_done), 32'b0100);
        chk("t1_idle", 32'(busy), 0);
        tick;
        chk("t1_done_pulse", 32'(req_done), 0);

        // rotation after requester 2: 3 before 1
        req_data = 32'h3300_1100;
        req_valid = 4'b1010;
        tick;
        chk("t3_gid_a", 32'(grant_id), 3);
        chk("t3_data_a", 32'(data_in), 32'h33);
        chk("t3_rdy_a", 32'(req_ready), 32'b1000);
        req_valid = 4'b0010;
        tick;
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
        chk("t3_done_a", 32'(req_done), 32'b1000);
        tick;
        chk("t3_gid_b", 32'(grant_id), 1);
        chk("t3_data_b", 32'(data_in), 32'h11);
        chk("t3_txs_b", 32'(tx_start), 1);
        req_valid = '0;
        tick;
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
        chk("t3_done_b", 32'(req_done), 32'b0010);

        // spurious tx_done in IDLE
        tick;
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
        chk("t6_spur_done", 32'(req_done), 0);
        chk("t6_spur_busy", {busy, tx_start}, 0);
        tick;
        chk("t6_spur_busy2", 32'(busy), 0);

        // all four held valid, tx_done in the 6th cycle after each tx_start
        do_reset;
        req_data = 32'h1312_1110;
        req_valid = 4'b1111;
        last_s = 0;
        for (int g = 0; g < 5; g++) begin
            wait_start($sformatf("t2_start%0d", g));
            chk($sformatf("t2_gid%0d", g), 32'(grant_id), 32'(order[g]));
            chk($sformatf("t2_data%0d", g), 32'(data_in), 32'h10 + 32'(order[g]));
            if (g > 0) chk($sformatf("t2_space%0d", g), cyc - last_s, 8);
            last_s = cyc;
            repeat (6) tick;
            tx_done = 1'b1;
            tick;
            tx_done = 1'b0;
            chk($sformatf("t2_done%0d", g), 32'(req_done), 32'(4'b0001 << order[g]));
        end
        req_valid = '0;

        // timeout on requester 1
        do_reset;
        req_data = 32'h0000_4455;
        req_valid = 4'b0010;
        tick;
        chk("t4_gid", 32'(grant_id), 1);
        req_valid = '0;
        n = 0;
        seen = '0;
        do begin
            tick;
            n++;
            seen |= req_done;
        end while (!timeout_err && n < 300);
        chk("t4_delay", n, 101);
        chk("t4_no_done", 32'(seen | req_done), 0);
        chk("t4_busy", 32'(busy), 0);
        tick;
        chk("t4_to_pulse", 32'(timeout_err), 0);
        req_valid = 4'b0011;
        tick;
        chk("t4_next_gid", 32'(grant_id), 0);
        chk("t4_next_data", 32'(data_in), 32'h55);
        req_valid = '0;

        // reset in the middle of WAIT
        do_reset;
        req_data = 32'h0066_0000;
        req_valid = 4'b0100;
        tick;
        req_valid = '0;
        repeat (10) tick;
        chk("t5_pre_busy", 32'(busy), 1);
        do_reset;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_outs", {req_ready, req_done, 6'd0, grant_id, data_in}, 0);
        chk("t5_flags", {tx_start, timeout_err}, 0);
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
        chk("t5_no_done", 32'(req_done), 0);
        req_data = 32'h1312_1110;
        req_valid = 4'b1111;
        tick;
        chk("t5_gid", 32'(grant_id), 0);
        chk("t5_txs", 32'(tx_start), 1);
        req_valid = '0;

        // tx_done on the timeout cycle wins
        do_reset;
        req_data = 32'h0000_0077;
        req_valid = 4'b0001;
        tick;
        req_valid = '0;
        seen = '0;
        for (int i = 0; i < 100; i++) begin
            tick;
            seen |= {3'd0, timeout_err};
        end
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
        chk("t6_sim_done", 32'(req_done), 32'b0001);
        chk("t6_sim_to", 32'(timeout_err | seen[0]), 0);
        chk("t6_sim_busy", 32'(busy), 0);
        tick;
        chk("t6_sim_to2", 32'(timeout_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
